fp_ci_master: RTL and testbench

FP_CI_MASTER -- requirements
Module: fp_ci_master

---
 rtl/fp_ci_master.sv | 109 ++++++++++
 tb/tb_fp_ci_master.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fp_ci_master.sv
// fp_ci_master: buffers operand pairs and issues them one at a time to an FP custom-instruction unit
module fp_ci_master #(
  parameter int          FIFO_DEPTH = 4,
  parameter int          TIMEOUT    = 255,
  parameter logic [31:0] NAN_WORD   = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  output logic [31:0] dataa,
  output logic [31:0] datab,
  output logic        enable,
  input  logic        done,
  input  logic [31:0] result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_timeout,
  output logic        busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t        r_state;
  logic [31:0]   r_fa [FIFO_DEPTH];
  logic [31:0]   r_fb [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic [15:0]   r_wcnt;
  logic [31:0]   r_dataa, r_datab, r_rsp_data;
  logic          r_enable, r_rsp_valid, r_rsp_timeout;
  logic          w_full, w_push, w_pop;
  assign w_full      = r_cnt == CW'(FIFO_DEPTH);
  assign w_push      = cmd_valid && !w_full;
  assign w_pop       = r_state == IDLE && r_cnt != '0;
  assign cmd_ready   = !w_full;
  assign busy        = r_state != IDLE;
  assign dataa       = r_dataa;
  assign datab       = r_datab;
  assign enable      = r_enable;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign rsp_timeout = r_rsp_timeout;
  // operand storage; validity is tracked by the pointers, so no reset is needed here
  always_ff @(posedge clk)
    if (w_push) begin
      r_fa[r_wp] <= cmd_a;
      r_fb[r_wp] <= cmd_b;
    end
  // pointers wrap naturally because the depth is a power of two
  always_ff @(posedge clk)
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      r_wp  <= w_push ? r_wp + 1'b1 : r_wp;
      r_rp  <= w_pop ? r_rp + 1'b1 : r_rp;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  // issue/wait/respond sequencer; done is ignored in the first WAIT cycle to reject a stale flag
  always_ff @(posedge clk)
    if (reset) begin
      r_state       <= IDLE;
      r_wcnt        <= '0;
      r_dataa       <= '0;
      r_datab       <= '0;
      r_enable      <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= '0;
      r_rsp_timeout <= 1'b0;
    end else begin
      case (r_state)
        IDLE:
          if (w_pop) begin
            r_dataa  <= r_fa[r_rp];
            r_datab  <= r_fb[r_rp];
            r_enable <= 1'b1;
            r_wcnt   <= '0;
            r_state  <= WAIT;
          end
        WAIT:
          if (r_wcnt != '0 && done) begin
            r_rsp_data    <= result;
            r_rsp_timeout <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_enable      <= 1'b0;
            r_state       <= RESP;
          end else if (r_wcnt == 16'(TIMEOUT)) begin
            r_rsp_data    <= NAN_WORD;
            r_rsp_timeout <= 1'b1;
            r_rsp_valid   <= 1'b1;
            r_enable      <= 1'b0;
            r_state       <= RESP;
          end else begin
            r_wcnt <= r_wcnt + 16'd1;
          end
        RESP:
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_fp_ci_master.sv
// tb_fp_ci_master: scoreboard bench with an FP unit model and directed scenarios
module tb_fp_ci_master;
  localparam int DEPTH = 4;
  localparam int TO    = 8;
  logic        clk = 0, reset = 1, cmd_valid = 0, rsp_ready = 1, done = 0;
  logic [31:0] cmd_a = 0, cmd_b = 0, result = 0;
  logic        cmd_ready, enable, rsp_valid, rsp_timeout, busy;
  logic [31:0] dataa, datab, rsp_data;
  int tests = 0, fails = 0;
  int mode = 0, ecnt = 0;
  logic [63:0] q[$];
  int occ = 0, occ_pre = 0, en_len = 0, exp_len = 0, rsp_cnt = 0, last_len = 0;
  logic [31:0] exp_rd = 0, last_rd = 0, p_da = 0, p_db = 0, p_rd = 0;
  logic exp_rt = 0, last_rt = 0, p_en = 0, p_rv = 0, p_rt = 0, p_crdy = 0;
  always #5 clk = ~clk;
  fp_ci_master #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TO), .NAN_WORD(32'h7FC00000)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .dataa(dataa), .datab(datab), .enable(enable),
    .done(done), .result(result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_timeout(rsp_timeout), .busy(busy));
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // FP unit model: mode 0 done after 3 enable cycles, 1 sticky done, 2 never done, 3 done exactly at the timeout cycle
  always @(negedge clk) begin
    ecnt   = enable ? ecnt + 1 : 0;
    done   = mode == 1 ? 1'b1 : mode == 2 ? 1'b0 : ecnt >= (mode == 0 ? 3 : TO + 1);
    result = mode == 1 ? 32'h12345678 : dataa ^ datab ^ 32'h40400000;
  end
  // scoreboard: per-cycle comparison against the queue of accepted pairs
  always begin
    @(posedge clk);
    #1;
    if (reset) begin
      q.delete();
      occ    = 0;
      en_len = 0;
      check("rst_enable", enable, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_rsp_timeout", rsp_timeout, 0);
      check("rst_dataa", dataa, 0);
      check("rst_datab", datab, 0);
    end else begin
      occ_pre = occ;
      if (cmd_valid && p_crdy) begin
        q.push_back({cmd_a, cmd_b});
        occ++;
      end
      if (!p_en && !p_rv && occ_pre > 0) check("issue_when_idle", enable, 1);
      if (enable && !p_en) begin
        check("issue_gap", p_rv, 0);
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL issue_empty: enable rose with no accepted pair pending");
        end else begin
          check("issue_dataa", dataa, q[0][63:32]);
          check("issue_datab", datab, q[0][31:0]);
          void'(q.pop_front());
          occ--;
        end
        en_len  = 1;
        exp_len = mode == 0 ? 3 : mode == 1 ? 2 : TO + 1;
        exp_rt  = mode == 2;
        exp_rd  = mode == 2 ? 32'h7FC00000 : mode == 1 ? 32'h12345678 : dataa ^ datab ^ 32'h40400000;
      end else if (enable) begin
        en_len++;
        check("dataa_stable", dataa, p_da);
        check("datab_stable", datab, p_db);
      end
      if (rsp_valid && !p_rv) check("rsp_from_wait", p_en && !enable, 1);
      if (!enable && p_en) begin
        check("enable_len", en_len, exp_len);
        check("rsp_valid_rise", rsp_valid, 1);
        check("rsp_data", rsp_data, exp_rd);
        check("rsp_timeout", rsp_timeout, exp_rt);
        rsp_cnt++;
        last_len = en_len;
        last_rd  = rsp_data;
        last_rt  = rsp_timeout;
      end
      if (p_rv && !rsp_ready) begin
        check("hold_valid", rsp_valid, 1);
        check("hold_data", rsp_data, p_rd);
        check("hold_timeout", rsp_timeout, p_rt);
      end else if (p_rv) begin
        check("rsp_release", rsp_valid, 0);
      end
      check("busy", busy, enable || rsp_valid);
      check("cmd_ready", cmd_ready, occ < DEPTH);
      check("no_overlap", enable && rsp_valid, 0);
    end
    p_en   = enable;
    p_rv   = rsp_valid;
    p_rt   = rsp_timeout;
    p_da   = dataa;
    p_db   = datab;
    p_rd   = rsp_data;
    p_crdy = cmd_ready;
  end
  task automatic push(input logic [31:0] a, input logic [31:0] b);
    int t = 0;
    cmd_valid = 1;
    cmd_a     = a;
    cmd_b     = b;
    while (!cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("push_timeout", 1, 0);
    @(negedge clk);
    cmd_valid = 0;
  endtask
  task automatic wait_rsp(input int n);
    int t = 0;
    while (rsp_cnt < n && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) check("wait_rsp_timeout", rsp_cnt, n);
    @(negedge clk);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    reset = 0;
    mode  = 0;
    push(32'h3FC00000, 32'h3FC00000);
    check("lat_edge_n", enable, 0);
    @(negedge clk);
    check("lat_edge_n1", enable, 1);
    wait_rsp(1);
    check("single_data", last_rd, 32'h40400000);
    check("single_timeout", last_rt, 0);
    check("single_en_len", last_len, 3);
    mode = 1;
    for (int i = 0; i < 4; i++) push(32'h10000000 + i, 32'h20000000 + i);
    wait_rsp(5);
    check("sticky_data", last_rd, 32'h12345678);
    check("sticky_en_len", last_len, 2);
    mode = 2;
    push(32'h3F800000, 32'h40000000);
    wait_rsp(6);
    check("to_data", last_rd, 32'h7FC00000);
    check("to_flag", last_rt, 1);
    check("to_en_len", last_len, 9);
    mode = 0;
    push(32'h40000000, 32'h40000000);
    wait_rsp(7);
    check("after_to_data", last_rd, 32'h40400000);
    check("after_to_flag", last_rt, 0);
    mode = 3;
    push(32'h00000001, 32'h00000002);
    wait_rsp(8);
    check("tie_data", last_rd, 32'h40400003);
    check("tie_flag", last_rt, 0);
    check("tie_en_len", last_len, 9);
    mode      = 0;
    rsp_ready = 0;
    for (int i = 0; i < 5; i++) push(32'hA0000000 + i, 32'h0B000000 + (i << 4));
    check("full_cmd_ready", cmd_ready, 0);
    check("full_busy", busy, 1);
    repeat (10) @(negedge clk);
    check("bp_enable", enable, 0);
    check("bp_valid", rsp_valid, 1);
    check("bp_data", rsp_data, 32'hEB400000);
    rsp_ready = 1;
    wait_rsp(13);
    mode = 2;
    for (int i = 0; i < 3; i++) push(32'h55000000 + i, 32'h00AA0000 + i);
    check("pre_reset_enable", enable, 1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("mid_reset_enable", enable, 0);
    check("mid_reset_valid", rsp_valid, 0);
    check("mid_reset_cmd_ready", cmd_ready, 1);
    check("mid_reset_busy", busy, 0);
    mode = 0;
    repeat (20) @(negedge clk);
    check("no_rsp_after_reset", rsp_cnt, 13);
    check("idle_after_reset", enable, 0);
    push(32'h12340000, 32'h00005678);
    wait_rsp(14);
    check("final_data", last_rd, 32'h52745678);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
